// File: rtl/nn_fp_pkg.sv
// nn_fp_pkg: shared single-precision constants, field widths and neuron FSM states
package nn_fp_pkg;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int EXP_BIAS = 127;
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_ONE = 32'h3F80_0000;
  localparam logic [31:0] FP_POS_INF = 32'h7F80_0000;
  localparam logic [31:0] FP_NEG_INF = 32'hFF80_0000;
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  function automatic logic [31:0] fp_inf(input logic s);
    return s ? FP_NEG_INF : FP_POS_INF;
  endfunction
endpackage

// File: rtl/fp_mac_unit.sv
// fp_mac_unit: combinational acc + a*b in single precision, truncating, zero/subnormal flushed to +0
module fp_mac_unit
  import nn_fp_pkg::*;
(
  input  logic [31:0] acc,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  logic             ps, pz, pinf, az, big_p, sub, rs;
  logic [47:0]      prod;
  logic [EXP_W-1:0] pe, ebig, esml, diff;
  logic [MAN_W:0]   pm, mbig, msml;
  logic [48:0]      fbig, fsml, sum, norm;
  logic [5:0]       lead;
  int               pe_i, re_i;
  always_comb begin
    prod = {24'b0, 1'b1, a[22:0]} * {24'b0, 1'b1, b[22:0]};
    pe_i = int'(a[30:23]) + int'(b[30:23]) - EXP_BIAS + int'(prod[47]);
    ps = a[31] ^ b[31];
    pz = a[30:23] == '0 || b[30:23] == '0 || pe_i <= 0;
    pinf = !pz && pe_i >= 255;
    pe = pe_i[7:0];
    pm = prod[47] ? {1'b1, prod[46:24]} : {1'b1, prod[45:23]};
    az = acc[30:23] == '0;
    big_p = {pe, pm[22:0]} > acc[30:0];
    ebig = big_p ? pe : acc[30:23];
    esml = big_p ? acc[30:23] : pe;
    mbig = big_p ? pm : {1'b1, acc[22:0]};
    msml = big_p ? {1'b1, acc[22:0]} : pm;
    rs = big_p ? ps : acc[31];
    sub = ps ^ acc[31];
    diff = ebig - esml;
    // 24 guard bits keep the aligned smaller operand's low bits through the add
    fbig = {1'b0, mbig, 24'b0};
    fsml = {1'b0, msml, 24'b0} >> diff;
    sum = sub ? fbig - fsml : fbig + fsml;
    lead = '0;
    for (int i = 0; i < 49; i++)
      if (sum[i]) lead = 6'(i);
    norm = sum << (6'd48 - lead);
    re_i = int'(ebig) + int'(lead) - 47;
    y = pinf ? fp_inf(ps) :
        pz ? (az ? FP_ZERO : acc) :
        az ? {ps, pe, pm[22:0]} :
        sum == '0 ? FP_ZERO :
        re_i >= 255 ? fp_inf(rs) :
        re_i <= 0 ? FP_ZERO : {rs, re_i[7:0], norm[47:25]};
  end
endmodule

// File: rtl/neuron_mac.sv
// neuron_mac: serial weighted sum z = bias + sum(x*w) with valid/ready handshakes
// NEURON_MAC_BIAS_EN adds the bias port; otherwise the sum starts from +0.0.
module neuron_mac
  import nn_fp_pkg::*;
#(
  parameter int N_INPUTS = 4
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
`ifdef NEURON_MAC_BIAS_EN
  input  logic [31:0] bias,
`endif
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x_in,
  input  logic [31:0] w_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] z,
  output logic        busy
);
  localparam int CW = $clog2(N_INPUTS + 1);
  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   acc, mac, init;
  fp_mac_unit u_mac (.acc(acc), .a(x_in), .b(w_in), .y(mac));
`ifdef NEURON_MAC_BIAS_EN
  assign init = bias;
`else
  assign init = FP_ZERO;
`endif
  assign z = acc;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      acc <= FP_ZERO;
      cnt <= '0;
      in_ready <= 1'b0;
      out_valid <= 1'b0;
      busy <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= ACC;
          acc <= init;
          cnt <= '0;
          in_ready <= 1'b1;
          busy <= 1'b1;
        end
        ACC: if (in_valid) begin
          acc <= mac;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(N_INPUTS - 1)) begin
            state <= DONE;
            in_ready <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          state <= IDLE;
          out_valid <= 1'b0;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_neuron_mac.sv
// tb_neuron_mac: scoreboard bench; expected sums come from exact real arithmetic re-encoded as floats
module tb_neuron_mac;
`ifdef NEURON_MAC_BIAS_EN
  localparam bit HAS_BIAS = 1'b1;
`else
  localparam bit HAS_BIAS = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, busy;
  logic [31:0] bias_v = '0, x_in = '0, w_in = '0, z;
  logic [31:0] xs [4], ws [4];
  int gs [4];
  logic [31:0] exp_q [$];
  int n_vec = 0, n_err = 0;
  logic hold = 1'b0;
  logic [31:0] held_z = '0;

  always #5 clk = ~clk;

  neuron_mac #(.N_INPUTS(4)) dut (
    .clk(clk), .reset(reset), .start(start),
`ifdef NEURON_MAC_BIAS_EN
    .bias(bias_v),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in), .w_in(w_in),
    .out_valid(out_valid), .out_ready(out_ready), .z(z), .busy(busy));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (r == 0.0) return 32'h0;
    return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
  endfunction

  always @(negedge clk) begin
    if (reset) hold <= 1'b0;
    else begin
      if (hold) begin
        chk("held_valid", {31'b0, out_valid}, 32'd1);
        chk("held_z", z, held_z);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_output", z, 32'hxxxxxxxx);
        else chk("z", z, exp_q.pop_front());
      end
      hold <= out_valid && !out_ready;
      held_z <= z;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pairs(input int npairs);
    for (int i = 0; i < npairs; i++) begin
      in_valid = 1'b0;
      repeat (gs[i]) tick();
      x_in = xs[i];
      w_in = ws[i];
      in_valid = 1'b1;
      for (int t = 0; t < 20 && !in_ready; t++) tick();
      if (!in_ready) chk("in_ready_timeout", {31'b0, in_ready}, 32'd1);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic run_eval(input logic [31:0] b, input logic [31:0] expv);
    exp_q.push_back(expv);
    bias_v = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("in_ready_after_start", {31'b0, in_ready}, 32'd1);
    send_pairs(4);
    chk("out_valid_after_last", {31'b0, out_valid}, 32'd1);
    chk("in_ready_in_done", {31'b0, in_ready}, 32'd0);
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 40 && busy; t++) tick();
    chk("idle_timeout", {31'b0, busy}, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    real xr [4], wr [4], br, acc;
    repeat (2) tick();
    reset = 1'b0;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_z", z, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    // bias 0.5, x = 1..4, w = 0.5, back-to-back
    xs = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    ws = '{32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h3F000000};
    gs = '{0, 0, 0, 0};
    run_eval(32'h3F000000, HAS_BIAS ? 32'h40B00000 : 32'h40A00000);
    wait_idle();
    // in_valid pattern 1,0,0,1,1,0,1 with x=1, w=-1
    xs = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
    ws = '{32'hBF800000, 32'hBF800000, 32'hBF800000, 32'hBF800000};
    gs = '{0, 2, 0, 1};
    run_eval(32'h0, 32'hC0800000);
    wait_idle();
    // output stall with start and in_valid pulsed while DONE
    out_ready = 1'b0;
    ws = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
    gs = '{0, 0, 0, 0};
    run_eval(32'h0, 32'h40800000);
    for (int i = 0; i < 10; i++) begin
      start = i[0];
      in_valid = ~i[0];
      tick();
      chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    start = 1'b1;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    chk("handshake_start_ignored", {31'b0, busy}, 32'd0);
    tick();
    chk("no_restart", {31'b0, busy}, 32'd0);
    // abort after two pairs, then a clean evaluation
    start = 1'b1;
    tick();
    start = 1'b0;
    xs = '{32'h40A00000, 32'h40A00000, 32'h0, 32'h0};
    send_pairs(2);
    do_reset();
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_z", z, 32'h0);
    xs = '{32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000};
    ws = '{32'h40400000, 32'h40400000, 32'h40400000, 32'h40400000};
    run_eval(32'h0, 32'h41C00000);
    wait_idle();
    // exact cancellation
    xs = '{32'h3F800000, 32'hBF800000, 32'h3F800000, 32'hBF800000};
    ws = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
    run_eval(32'h0, 32'h0);
    wait_idle();
    // product exponent overflow
    xs = '{32'h0, 32'h0, 32'h0, 32'h7F000000};
    ws = '{32'h0, 32'h0, 32'h0, 32'h7F000000};
    run_eval(32'h0, 32'h7F800000);
    wait_idle();
    // subnormal activation counts as zero
    xs = '{32'h00000001, 32'h40000000, 32'h40400000, 32'h3F800000};
    ws = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
    run_eval(32'h0, 32'h40C00000);
    wait_idle();
    // random exactly-representable operands against real arithmetic
    for (int e = 0; e < 24; e++) begin
      br = HAS_BIAS ? (real'(int'($urandom_range(32))) - 16.0) / 2.0 : 0.0;
      acc = br;
      for (int i = 0; i < 4; i++) begin
        xr[i] = real'(int'($urandom_range(32))) - 16.0;
        wr[i] = (2.0 ** (real'(int'($urandom_range(4))) - 2.0)) * ($urandom_range(1) == 1 ? -1.0 : 1.0);
        acc += xr[i] * wr[i];
        xs[i] = r2f(xr[i]);
        ws[i] = r2f(wr[i]);
        gs[i] = int'($urandom_range(2));
      end
      run_eval(r2f(br), r2f(acc));
      wait_idle();
      repeat ($urandom_range(2)) tick();
    end
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
